switch_reg_writer: RTL and testbench
====================================

Name: switch_reg_writer

Overview:
- Write-side companion to the switch-to-LED register readout.
- Loads an 8-entry x 8-bit register bank from board switches. The write address comes from 3 switches and the data from 8 switches.
- A write is committed once per debounced press of a write button.
- A combinational read port lets the LED display path select and show any entry.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required to accept a button press or release (>=2).
- DATA_W, 8, register width.
- ADDR_W, 3, address width; bank depth = 2**ADDR_W.
- INIT0, 8'b10011001, reset value of entry 0.
- INIT1, 8'b01100110, reset value of entry 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- switch  input  ADDR_W  write address switches (asynchronous).
- data_sw  input  DATA_W  write data switches (asynchronous).
- btn_wr  input  1  write push-button (asynchronous, bouncy, active-high).
- rd_addr  input  ADDR_W  read select.
- rd_data  output  DATA_W  bank[rd_addr], combinational.
- wr_done  output  1  one-cycle pulse on each committed write.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-low):
  - entry0=INIT0, entry1=INIT1, entries 2..7 = 0.
  - FSM=IDLE, debounce counter=0, synchronizers=0.
  - wr_done=0, busy=0.
  - rd_data reflects the reset contents immediately.
- Synchronization: btn_wr, switch and data_sw each pass through 2-flop synchronizers, giving btn_s, addr_s and data_s. The synchronizer latency is 2 cycles.
- FSM states: IDLE, PRESS, WRITE, RELEASE.
- IDLE:
  - cnt=0.
  - btn_s=1 -> PRESS with cnt=1.
- PRESS:
  - btn_s=0 -> IDLE, cnt=0 (glitch rejected).
  - btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> WRITE.
  - Otherwise cnt++.
- WRITE (exactly 1 cycle):
  - At the clock edge leaving WRITE: bank[addr_s] <= data_s, and wr_done is registered to 1 for the following cycle only.
  - Then go to RELEASE with cnt=0.
- RELEASE:
  - btn_s=1 -> cnt=0.
  - btn_s=0 -> cnt++.
  - cnt==DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE.
  - Holding the button never produces a second write.
- Timing and data capture:
  - Latency from btn_s rising and staying stable to the bank update is DEBOUNCE_CYCLES+1 clk edges.
  - rd_data shows the new value in the same cycle wr_done is high.
  - Address and data are sampled only in the WRITE cycle. Switch changes during PRESS or RELEASE do not affect a write already committed.
- Read/write collision: rd_addr == write address in the WRITE cycle -> rd_data shows the old value during WRITE and the new value from the next cycle. There is no bypass.
- Entries 0 and 1 are writable; INIT values apply only at reset.
- Counter width: $clog2(DEBOUNCE_CYCLES)+1. The counter never wraps because it saturates at the compare value.
- Reset asserted mid-PRESS, WRITE or RELEASE aborts any pending write. The bank returns to its INIT contents, and no wr_done pulse follows the reset.

Decomposition:
- Shared package: state enum (IDLE, PRESS, WRITE, RELEASE), DATA_W/ADDR_W defaults, INIT0/INIT1 constants. The existing LED readout uses the same constants.
- Sub-module btn_debounce: synchronizer, counter and PRESS/RELEASE logic. It emits a one-cycle press_pulse. The top module holds the bank, the WRITE state and the read mux.

Test Plan (DEBOUNCE_CYCLES=4):
1. Release reset, then sweep rd_addr 0..7 -> rd_data = 8'h99, 8'h66, 0, 0, 0, 0, 0, 0; busy=0; wr_done=0.
2. switch=3, data_sw=8'hA5, btn_wr high for 2 cycles then low -> no write, entry3 stays 0, wr_done stays 0, FSM returns to IDLE.
3. switch=3, data_sw=8'hA5, btn_wr held high -> exactly one wr_done pulse, 5 edges after btn_s rises; rd_addr=3 then reads 8'hA5.
4. Keep btn_wr held 50 cycles, change data_sw=8'h3C, release and bounce (1-cycle highs) before a clean low -> no second write, entry3=8'hA5; busy drops only after 4 clean low cycles.
5. switch=0, data_sw=8'h00 with a press -> entry0=8'h00. Pulse rst_n -> entry0 back to 8'h99.
6. Assert rst_n low during PRESS at cnt=2 -> no write, no wr_done; the bank equals the INIT contents after reset.

Source files
------------

// File: rtl/switch_reg_writer_pkg.sv
// Shared definitions for the switch-driven register bank (writer side) and
// the LED readout path: default widths, entry reset values and the button
// FSM state encoding.
package switch_reg_writer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic [7:0] INIT0_DEF = 8'b10011001;
  localparam logic [7:0] INIT1_DEF = 8'b01100110;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    WRITE   = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Write-button conditioner: 2-flop synchronizer, debounce counter and the
// IDLE/PRESS/WRITE/RELEASE state machine.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   btn          - raw push-button (asynchronous, bouncy, active-high)
//   press_pulse  - high for exactly one cycle (the WRITE state) per press
//   state        - current FSM state (registered)
module btn_debounce
  import switch_reg_writer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   btn,
  output logic   press_pulse,
  output state_t state
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       btn_sync;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;

  assign btn_s = btn_sync[1];

  // Counter only ever advances up to CNT_MAX, where the FSM leaves the
  // state, so it cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= '0;
      state    <= IDLE;
      cnt      <= '0;
    end else begin
      btn_sync <= {btn_sync[0], btn};
      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) begin
            state <= PRESS;
            cnt   <= CNT_W'(1);
          end
        end
        PRESS: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= WRITE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          state <= RELEASE;
          cnt   <= '0;
        end
        RELEASE: begin
          // Any high sample restarts the release window, so bounce on the
          // way up cannot retrigger a write.
          if (btn_s) begin
            cnt <= '0;
          end else if (cnt == CNT_MAX) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign press_pulse = (state == WRITE);

endmodule

// File: rtl/switch_reg_writer.sv
// Switch-loaded register bank: each debounced press of btn_wr writes the
// data switches into the entry selected by the address switches. A
// combinational read port serves the LED display path.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   switch     - write address switches (asynchronous)
//   data_sw    - write data switches (asynchronous)
//   btn_wr     - write push-button (asynchronous, bouncy, active-high)
//   rd_addr    - read select
//   rd_data    - bank[rd_addr], combinational
//   wr_done    - one-cycle pulse after each committed write
//   busy       - high whenever the button FSM is not idle
module switch_reg_writer
  import switch_reg_writer_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               DATA_W          = DATA_W_DEF,
  parameter int               ADDR_W          = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] INIT0          = DATA_W'(INIT0_DEF),
  parameter logic [DATA_W-1:0] INIT1          = DATA_W'(INIT1_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] switch,
  input  logic [DATA_W-1:0] data_sw,
  input  logic              btn_wr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              wr_done,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] addr_sync0, addr_s;
  logic [DATA_W-1:0] data_sync0, data_s;
  logic [DATA_W-1:0] bank [DEPTH];
  logic              press_pulse;
  state_t            state;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn_wr),
    .press_pulse(press_pulse),
    .state      (state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_sync0 <= '0;
      addr_s     <= '0;
      data_sync0 <= '0;
      data_s     <= '0;
    end else begin
      addr_sync0 <= switch;
      addr_s     <= addr_sync0;
      data_sync0 <= data_sw;
      data_s     <= data_sync0;
    end
  end

  // Address/data are taken only on the edge leaving WRITE; switch
  // movement at any other time has no effect on the bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank[i] <= (i == 0) ? INIT0 : (i == 1) ? INIT1 : '0;
      end
      wr_done <= 1'b0;
    end else begin
      if (press_pulse) begin
        bank[addr_s] <= data_s;
      end
      wr_done <= press_pulse;
    end
  end

  // No write bypass: a read of the entry being written shows the old value
  // during WRITE and the new one from the wr_done cycle onward.
  assign rd_data = bank[rd_addr];
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_switch_reg_writer.sv
module tb_switch_reg_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] switch;
  logic [7:0] data_sw;
  logic       btn_wr;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_done;
  logic       busy;

  always #5 clk = ~clk;

  switch_reg_writer #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .switch (switch),
    .data_sw(data_sw),
    .btn_wr (btn_wr),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_done(wr_done),
    .busy   (busy)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } sb_t;

  rd_vec_t init_tbl[8];
  sb_t     sb_q[$];
  int      checks = 0;
  int      errors = 0;
  int      wr_count = 0;
  bit      wr_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the rising edge and any
  // wr_done pulse is matched against the scoreboard.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    wr_seen = wr_done;
    if (wr_done) begin
      wr_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wr_done got 1 want 0 at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        rd_addr = e.addr;
        #0;
        if (rd_data !== e.data) begin
          errors++;
          $display("FAIL sb_wr_data addr %0d got %0h want %0h", e.addr, rd_data, e.data);
        end
      end
    end
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 8; i++) begin
      rd_addr = init_tbl[i].addr;
      #1;
      chk($sformatf("%s_rd%0d", tag, i), {24'd0, rd_data}, {24'd0, init_tbl[i].exp});
    end
  endtask

  task automatic press_wait(input logic [2:0] a, input logic [7:0] d, output int n);
    switch  = a;
    data_sw = d;
    rd_addr = a;
    btn_wr  = 1'b1;
    sb_q.push_back('{addr: a, data: d});
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (wr_seen) begin
        n = k;
        break;
      end
    end
    chk("press_wr_seen", {31'd0, (n != 0)}, 32'd1);
  endtask

  task automatic release_wait(output int n);
    btn_wr = 1'b0;
    n = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (!busy) begin
        n = k;
        break;
      end
    end
    chk("release_idle", {31'd0, (n != 0)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  saw_busy;

    init_tbl[0] = '{addr: 3'd0, exp: 8'h99};
    init_tbl[1] = '{addr: 3'd1, exp: 8'h66};
    for (int i = 2; i < 8; i++) init_tbl[i] = '{addr: 3'(i), exp: 8'h00};

    rst_n = 1'b0; switch = '0; data_sw = '0; btn_wr = 1'b0; rd_addr = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_done", {31'd0, wr_done}, 32'd0);
    sweep("rst");
    rst_n = 1'b1;
    tick(); tick();

    // 1: post-reset contents
    sweep("init");
    chk("init_busy", {31'd0, busy}, 32'd0);
    chk("init_wr_done", {31'd0, wr_done}, 32'd0);

    // 2: two-cycle glitch is rejected
    switch = 3'd3; data_sw = 8'hA5; rd_addr = 3'd3;
    btn_wr = 1'b1;
    tick(); tick();
    btn_wr = 1'b0;
    saw_busy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (busy) saw_busy = 1;
    end
    chk("glitch_saw_press", {31'd0, saw_busy}, 32'd1);
    chk("glitch_idle", {31'd0, busy}, 32'd0);
    chk("glitch_entry3", {24'd0, rd_data}, 32'h00);
    chk("glitch_wr_count", wr_count, 0);

    // 3: clean press, latency = 2 sync + 5 FSM edges; old value during WRITE
    switch = 3'd3; data_sw = 8'hA5; rd_addr = 3'd3; btn_wr = 1'b1;
    sb_q.push_back('{addr: 3'd3, data: 8'hA5});
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 6) begin
        chk("collision_old", {24'd0, rd_data}, 32'h00);
        chk("collision_busy", {31'd0, busy}, 32'd1);
      end
      if (wr_seen) begin
        n = k;
        break;
      end
    end
    chk("wr_latency", n, 7);
    tick();
    chk("wr_done_one_cycle", {31'd0, wr_done}, 32'd0);
    chk("entry3_a5", {24'd0, rd_data}, 32'hA5);

    // 4: hold, change data, bounce on release
    for (int k = 0; k < 50; k++) begin
      if (k == 5) data_sw = 8'h3C;
      tick();
    end
    chk("hold_busy", {31'd0, busy}, 32'd1);
    btn_wr = 1'b0; tick(); tick();
    btn_wr = 1'b1; tick();
    btn_wr = 1'b0; tick(); tick();
    btn_wr = 1'b1; tick();
    btn_wr = 1'b0;
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) chk("bounce_busy_k5", {31'd0, busy}, 32'd1);
      if (!busy) begin
        n = k;
        break;
      end
    end
    chk("release_latency", n, 6);
    chk("hold_wr_count", wr_count, 1);
    rd_addr = 3'd3; #1;
    chk("hold_entry3", {24'd0, rd_data}, 32'hA5);

    // 5: entry 0 is writable; reset restores INIT
    press_wait(3'd0, 8'h00, n);
    release_wait(n);
    rd_addr = 3'd0; #1;
    chk("entry0_zero", {24'd0, rd_data}, 32'h00);
    rst_n = 1'b0; #1;
    chk("entry0_async_rst", {24'd0, rd_data}, 32'h99);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // 6: reset during PRESS aborts the pending write
    press_wait(3'd2, 8'h5A, n);
    release_wait(n);
    rd_addr = 3'd2; #1;
    chk("entry2_5a", {24'd0, rd_data}, 32'h5A);
    n = wr_count;
    switch = 3'd1; data_sw = 8'hFF; btn_wr = 1'b1;
    tick(); tick(); tick(); tick();
    chk("abort_in_press", {31'd0, busy}, 32'd1);
    rst_n = 1'b0; btn_wr = 1'b0; #1;
    chk("abort_rst_busy", {31'd0, busy}, 32'd0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) tick();
    chk("abort_wr_count", wr_count, n);
    sweep("abort");
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
